// File: rtl/sys_defs.sv
// sys_defs: shared definitions for the memory-port arbiter.
//   MEM_SIZE        - access size encoding used on LSQ and dcache ports
//   ARB_STATE       - arbiter FSM state encoding
//   MEM_TAG_W       - default width of the dcache load tag
//   MEM_STARVE_MAX  - default lost-arbitration limit in age mode
package sys_defs;

  localparam int MEM_TAG_W      = 3;
  localparam int MEM_STARVE_MAX = 4;

  typedef enum logic [1:0] {
    MEM_BYTE   = 2'd0,
    MEM_HALF   = 2'd1,
    MEM_WORD   = 2'd2,
    MEM_DOUBLE = 2'd3
  } MEM_SIZE;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_HOLD    = 2'd1,
    ARB_WAIT_LD = 2'd2
  } ARB_STATE;

endpackage

// File: rtl/mem_arb_age_ctr.sv
// mem_arb_age_ctr: saturating count of consecutive lost arbitrations.
//   clock, reset  - rising-edge clock, synchronous active-high reset
//   i_lose        - requester was valid in an arbitration cycle and lost
//   i_win         - requester was granted (clears the count)
//   o_starved     - count has reached MAX
module mem_arb_age_ctr #(
  parameter int MAX = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic i_lose,
  input  logic i_win,
  output logic o_starved
);

  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_win) begin
      r_cnt <= '0;
    end else if (i_lose && (r_cnt != W'(MAX))) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_starved = (r_cnt == W'(MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: single dcache port shared by LSQ loads and retired-store
// drains. One request is registered and held toward the dcache until accepted;
// at most one load is outstanding, matched back by a wrapping tag.
//   clock, reset                  - rising-edge clock, sync active-high reset
//   ld_req_* / st_req_*           - load / store request handshakes from LSQ
//   dc_req_*                      - held request to dcache, dc_req_accept ends it
//   dc_rsp_*                      - dcache load response (tag matched)
//   ld_rsp_valid / ld_rsp_data    - registered load result to LSQ
//   flush                         - squashes load traffic, never held stores
// Build option: define MEM_ARB_AGE_EN for anti-starvation arbitration (a load
// that lost STARVE_MAX consecutive arbitrations beats a pending store).
// Without it, stores always take priority.
module mem_port_arbiter
  import sys_defs::*;
#(
  parameter int TAG_W      = MEM_TAG_W,
  parameter int STARVE_MAX = MEM_STARVE_MAX
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ld_req_valid,
  output logic             ld_req_ready,
  input  logic [31:0]      ld_req_addr,
  input  MEM_SIZE          ld_req_size,
  input  logic             st_req_valid,
  output logic             st_req_ready,
  input  logic [31:0]      st_req_addr,
  input  logic [63:0]      st_req_data,
  input  MEM_SIZE          st_req_size,
  output logic             dc_req_valid,
  output logic             dc_req_is_store,
  output logic [31:0]      dc_req_addr,
  output logic [63:0]      dc_req_data,
  output MEM_SIZE          dc_req_size,
  output logic [TAG_W-1:0] dc_req_tag,
  input  logic             dc_req_accept,
  input  logic             dc_rsp_valid,
  input  logic [TAG_W-1:0] dc_rsp_tag,
  input  logic [63:0]      dc_rsp_data,
  output logic             ld_rsp_valid,
  output logic [63:0]      ld_rsp_data,
  input  logic             flush
);

  ARB_STATE         r_state;
  logic             r_is_store;
  logic [31:0]      r_addr;
  logic [63:0]      r_data;
  MEM_SIZE          r_size;
  logic [TAG_W-1:0] r_tag;
  logic [TAG_W-1:0] r_wait_tag;
  logic             r_rsp_valid;
  logic [63:0]      r_rsp_data;

  logic w_idle;
  logic w_ld_win;
  logic w_st_win;
  logic w_ld_force;

  // Grants are gated by reset so no ready is seen while reset is asserted.
  assign w_idle = (r_state == ARB_IDLE) && !reset;

`ifdef MEM_ARB_AGE_EN
  logic w_ld_starved;
  logic w_st_starved;

  mem_arb_age_ctr #(.MAX(STARVE_MAX)) u_ld_age (
    .clock     (clock),
    .reset     (reset),
    .i_lose    (w_idle && ld_req_valid && !w_ld_win),
    .i_win     (w_ld_win),
    .o_starved (w_ld_starved)
  );

  mem_arb_age_ctr #(.MAX(STARVE_MAX)) u_st_age (
    .clock     (clock),
    .reset     (reset),
    .i_lose    (w_idle && st_req_valid && !w_st_win),
    .i_win     (w_st_win),
    .o_starved (w_st_starved)
  );

  assign w_ld_force = w_ld_starved && !w_st_starved;
`else
  assign w_ld_force = 1'b0;
`endif

  // A flush in IDLE blocks the load grant; a store may still go that cycle.
  assign w_ld_win = w_idle && ld_req_valid && !flush && (!st_req_valid || w_ld_force);
  assign w_st_win = w_idle && st_req_valid && !w_ld_win;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ARB_IDLE;
      r_is_store  <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_size      <= MEM_BYTE;
      r_tag       <= '0;
      r_wait_tag  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (w_st_win) begin
            r_is_store <= 1'b1;
            r_addr     <= st_req_addr;
            r_data     <= st_req_data;
            r_size     <= st_req_size;
            r_state    <= ARB_HOLD;
          end else if (w_ld_win) begin
            r_is_store <= 1'b0;
            r_addr     <= ld_req_addr;
            r_data     <= '0;
            r_size     <= ld_req_size;
            r_state    <= ARB_HOLD;
          end
        end
        ARB_HOLD: begin
          if (r_is_store) begin
            if (dc_req_accept) begin
              r_state <= ARB_IDLE;
            end
          end else if (flush) begin
            // The dcache may already have taken it; retire that tag so a
            // late response for it can never match a later load.
            if (dc_req_accept) begin
              r_tag <= r_tag + 1'b1;
            end
            r_state <= ARB_IDLE;
          end else if (dc_req_accept) begin
            r_wait_tag <= r_tag;
            r_tag      <= r_tag + 1'b1;
            r_state    <= ARB_WAIT_LD;
          end
        end
        ARB_WAIT_LD: begin
          // The tag counter already advanced at accept, so after a flush the
          // next load carries a different tag than the abandoned one.
          if (flush) begin
            r_state <= ARB_IDLE;
          end else if (dc_rsp_valid && (dc_rsp_tag == r_wait_tag)) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= dc_rsp_data;
            r_state     <= ARB_IDLE;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign ld_req_ready    = w_ld_win;
  assign st_req_ready    = w_st_win;
  assign dc_req_valid    = (r_state == ARB_HOLD);
  assign dc_req_is_store = r_is_store;
  assign dc_req_addr     = r_addr;
  assign dc_req_data     = r_data;
  assign dc_req_size     = r_size;
  assign dc_req_tag      = r_tag;
  assign ld_rsp_valid    = r_rsp_valid;
  assign ld_rsp_data     = r_rsp_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  import sys_defs::*;

  localparam int TAG_W      = 3;
  localparam int STARVE_MAX = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic             ld_req_valid, ld_req_ready;
  logic [31:0]      ld_req_addr;
  MEM_SIZE          ld_req_size;
  logic             st_req_valid, st_req_ready;
  logic [31:0]      st_req_addr;
  logic [63:0]      st_req_data;
  MEM_SIZE          st_req_size;
  logic             dc_req_valid, dc_req_is_store;
  logic [31:0]      dc_req_addr;
  logic [63:0]      dc_req_data;
  MEM_SIZE          dc_req_size;
  logic [TAG_W-1:0] dc_req_tag;
  logic             dc_req_accept;
  logic             dc_rsp_valid;
  logic [TAG_W-1:0] dc_rsp_tag;
  logic [63:0]      dc_rsp_data;
  logic             ld_rsp_valid;
  logic [63:0]      ld_rsp_data;
  logic             flush;

  always #5 clock = ~clock;

  mem_port_arbiter #(.TAG_W(TAG_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clock           (clock),
    .reset           (reset),
    .ld_req_valid    (ld_req_valid),
    .ld_req_ready    (ld_req_ready),
    .ld_req_addr     (ld_req_addr),
    .ld_req_size     (ld_req_size),
    .st_req_valid    (st_req_valid),
    .st_req_ready    (st_req_ready),
    .st_req_addr     (st_req_addr),
    .st_req_data     (st_req_data),
    .st_req_size     (st_req_size),
    .dc_req_valid    (dc_req_valid),
    .dc_req_is_store (dc_req_is_store),
    .dc_req_addr     (dc_req_addr),
    .dc_req_data     (dc_req_data),
    .dc_req_size     (dc_req_size),
    .dc_req_tag      (dc_req_tag),
    .dc_req_accept   (dc_req_accept),
    .dc_rsp_valid    (dc_rsp_valid),
    .dc_rsp_tag      (dc_rsp_tag),
    .dc_rsp_data     (dc_rsp_data),
    .ld_rsp_valid    (ld_rsp_valid),
    .ld_rsp_data     (ld_rsp_data),
    .flush           (flush)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    bit          rst, lv, sv, acc, rv, fl;
    logic [31:0] la, sa;
    logic [63:0] sd, rd;
    logic [1:0]  lsz, ssz;
    logic [2:0]  rt;
  } stim_t;

  // Reference model: one slot (free / presenting / awaiting response),
  // a count of accepted loads, and a pending response to deliver.
  int               m_phase;  // 0 free, 1 presenting to dcache, 2 awaiting load data
  bit               m_is_store;
  logic [31:0]      m_addr;
  logic [63:0]      m_data;
  logic [1:0]       m_size;
  logic [TAG_W-1:0] m_tag;
  logic [TAG_W-1:0] m_wait_tag;
  bit               m_rsp;
  logic [63:0]      m_rsp_data;
  int               m_ld_loss;
  bit               obs_ld_ready;

  function automatic void model_reset();
    m_phase = 0; m_is_store = 0; m_addr = '0; m_data = '0; m_size = '0;
    m_tag = '0; m_wait_tag = '0; m_rsp = 0; m_rsp_data = '0; m_ld_loss = 0;
  endfunction

  function automatic stim_t nop();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.rst = ($urandom_range(0, 299) == 0);
    s.lv  = ($urandom_range(0, 1) == 1);
    s.sv  = ($urandom_range(0, 2) == 0);
    s.acc = ($urandom_range(0, 1) == 1);
    s.rv  = ($urandom_range(0, 2) == 0);
    s.fl  = ($urandom_range(0, 9) == 0);
    s.la  = $urandom;
    s.sa  = $urandom;
    s.sd  = {$urandom, $urandom};
    s.rd  = {$urandom, $urandom};
    s.lsz = 2'($urandom_range(0, 3));
    s.ssz = 2'($urandom_range(0, 3));
    s.rt  = ($urandom_range(0, 1) == 1) ? m_wait_tag : 3'($urandom_range(0, 7));
    return s;
  endfunction

  // Called at a falling edge: drive, check, advance the model, wait for next falling edge.
  task automatic step(input stim_t s);
    bit ld_force, exp_ld, exp_st, rsp_next;
    reset         = s.rst;
    ld_req_valid  = s.lv;
    ld_req_addr   = s.la;
    ld_req_size   = MEM_SIZE'(s.lsz);
    st_req_valid  = s.sv;
    st_req_addr   = s.sa;
    st_req_data   = s.sd;
    st_req_size   = MEM_SIZE'(s.ssz);
    dc_req_accept = s.acc;
    dc_rsp_valid  = s.rv;
    dc_rsp_tag    = s.rt;
    dc_rsp_data   = s.rd;
    flush         = s.fl;
    #1;
`ifdef MEM_ARB_AGE_EN
    ld_force = (m_ld_loss >= STARVE_MAX);
`else
    ld_force = 0;
`endif
    exp_ld = !s.rst && (m_phase == 0) && s.lv && !s.fl && (!s.sv || ld_force);
    exp_st = !s.rst && (m_phase == 0) && s.sv && !exp_ld;
    obs_ld_ready = ld_req_ready;
    chk("ld_req_ready", 64'(ld_req_ready), 64'(exp_ld));
    chk("st_req_ready", 64'(st_req_ready), 64'(exp_st));
    chk("dc_req_valid", 64'(dc_req_valid), 64'(m_phase == 1));
    chk("dc_req_tag", 64'(dc_req_tag), 64'(m_tag));
    if (m_phase == 1) begin
      chk("dc_req_is_store", 64'(dc_req_is_store), 64'(m_is_store));
      chk("dc_req_addr", 64'(dc_req_addr), 64'(m_addr));
      chk("dc_req_size", 64'(dc_req_size), 64'(m_size));
      if (m_is_store) chk("dc_req_data", dc_req_data, m_data);
    end
    chk("ld_rsp_valid", 64'(ld_rsp_valid), 64'(m_rsp));
    if (m_rsp) chk("ld_rsp_data", ld_rsp_data, m_rsp_data);

    rsp_next = 0;
    if (s.rst) begin
      model_reset();
    end else begin
      if (m_phase == 0) begin
        if (s.lv) m_ld_loss = exp_ld ? 0 : ((m_ld_loss < STARVE_MAX) ? m_ld_loss + 1 : STARVE_MAX);
        if (exp_st) begin
          m_phase = 1; m_is_store = 1; m_addr = s.sa; m_data = s.sd; m_size = s.ssz;
        end else if (exp_ld) begin
          m_phase = 1; m_is_store = 0; m_addr = s.la; m_size = s.lsz;
        end
      end else if (m_phase == 1) begin
        if (m_is_store) begin
          if (s.acc) m_phase = 0;
        end else if (s.fl) begin
          if (s.acc) m_tag = m_tag + 1'b1;
          m_phase = 0;
        end else if (s.acc) begin
          m_wait_tag = m_tag;
          m_tag      = m_tag + 1'b1;
          m_phase    = 2;
        end
      end else begin
        if (s.fl) begin
          m_phase = 0;
        end else if (s.rv && (s.rt == m_wait_tag)) begin
          rsp_next = 1; m_rsp_data = s.rd; m_phase = 0;
        end
      end
      m_rsp = rsp_next;
    end
    @(negedge clock);
  endtask

  task automatic do_reset();
    stim_t s;
    s = nop(); s.rst = 1; s.lv = 1; s.sv = 1;
    step(s);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    stim_t s;
    int    arbs, first_arb, ld_grants;
    bit    was_idle;

    reset = 1; ld_req_valid = 0; ld_req_addr = '0; ld_req_size = MEM_BYTE;
    st_req_valid = 0; st_req_addr = '0; st_req_data = '0; st_req_size = MEM_BYTE;
    dc_req_accept = 0; dc_rsp_valid = 0; dc_rsp_tag = '0; dc_rsp_data = '0; flush = 0;
    @(negedge clock);
    chk("rst_dc_req_valid", 64'(dc_req_valid), 64'd0);
    chk("rst_dc_req_is_store", 64'(dc_req_is_store), 64'd0);
    chk("rst_dc_req_addr", 64'(dc_req_addr), 64'd0);
    chk("rst_dc_req_data", dc_req_data, 64'd0);
    chk("rst_dc_req_size", 64'(dc_req_size), 64'd0);
    chk("rst_dc_req_tag", 64'(dc_req_tag), 64'd0);
    chk("rst_ld_rsp_valid", 64'(ld_rsp_valid), 64'd0);
    chk("rst_ld_rsp_data", ld_rsp_data, 64'd0);
    chk("rst_ld_req_ready", 64'(ld_req_ready), 64'd0);
    chk("rst_st_req_ready", 64'(st_req_ready), 64'd0);
    model_reset();
    do_reset();

    // Lone load, accepted after two held cycles, response tag 0.
    s = nop(); s.lv = 1; s.la = 32'h100; s.lsz = 2'd2; step(s);
    s = nop(); step(s); step(s);
    s.acc = 1; step(s);
    s = nop(); s.rv = 1; s.rt = 3'd0; s.rd = 64'hDEAD; step(s);
    chk("r033_rsp_valid", 64'(ld_rsp_valid), 64'd1);
    chk("r033_rsp_data", ld_rsp_data, 64'hDEAD);
    chk("r033_tag", 64'(dc_req_tag), 64'd1);

    // Load and store together: store first, load in the next IDLE.
    do_reset();
    s = nop(); s.lv = 1; s.sv = 1; s.la = 32'h300; s.sa = 32'h200;
    s.sd = 64'h1234_5678_9ABC_DEF0; step(s);
    chk("r034_store_first", 64'(dc_req_is_store), 64'd1);
    s.sv = 0; s.acc = 1; step(s);
    s.acc = 0; step(s);
    chk("r034_ld_granted", 64'(obs_ld_ready), 64'd1);
    chk("r034_ld_addr", 64'(dc_req_addr), 64'h300);

    // Flush while awaiting load data; stale tag-0 response must be dropped.
    do_reset();
    s = nop(); s.lv = 1; s.la = 32'h400; step(s);
    s = nop(); s.acc = 1; step(s);
    s = nop(); s.fl = 1; step(s);
    s = nop(); s.rv = 1; s.rt = 3'd0; s.rd = 64'hBAD; step(s);
    chk("r035_no_rsp", 64'(ld_rsp_valid), 64'd0);
    s = nop(); s.lv = 1; s.la = 32'h404; step(s);
    chk("r035_next_tag", 64'(dc_req_tag), 64'd1);

    // Flush does not disturb a held store.
    do_reset();
    s = nop(); s.sv = 1; s.sa = 32'hA0; s.sd = 64'hCAFE; step(s);
    s = nop(); s.fl = 1;
    for (int i = 0; i < 3; i++) begin
      step(s);
      chk("r036_valid", 64'(dc_req_valid), 64'd1);
      chk("r036_addr", 64'(dc_req_addr), 64'hA0);
      chk("r036_data", dc_req_data, 64'hCAFE);
    end
    s.acc = 1; step(s);
    chk("r036_done", 64'(dc_req_valid), 64'd0);

    // Continuous stores and load: starvation behaviour.
    do_reset();
    arbs = 0; first_arb = 0; ld_grants = 0;
    s = nop(); s.lv = 1; s.sv = 1; s.acc = 1;
    for (int i = 0; i < 40; i++) begin
      was_idle = (m_phase == 0);
      s.sa = 32'h800 + 32'(i);
      step(s);
      if (was_idle) arbs++;
      if (obs_ld_ready) begin
        ld_grants++;
        if (first_arb == 0) first_arb = arbs;
      end
    end
`ifdef MEM_ARB_AGE_EN
    chk("r037_grant_arb", 64'(first_arb), 64'd5);
`else
    chk("r037_no_ld_grant", 64'(ld_grants), 64'd0);
`endif

    // Eight loads with mismatched responses in between: tag wraps.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      s = nop(); s.lv = 1; s.la = 32'h1000 + 32'(k * 8); step(s);
      chk("r038_issue_tag", 64'(dc_req_tag), 64'(k));
      s = nop(); s.acc = 1; step(s);
      s = nop(); s.rv = 1; s.rt = 3'(k + 3); s.rd = 64'hEEEE; step(s);
      chk("r038_ignored", 64'(ld_rsp_valid), 64'd0);
      s.rt = 3'(k); s.rd = 64'hF00 + 64'(k); step(s);
      chk("r038_rsp", ld_rsp_data, 64'hF00 + 64'(k));
    end
    chk("r038_wrap", 64'(dc_req_tag), 64'd0);

    // Reset while a load is outstanding abandons it.
    do_reset();
    s = nop(); s.lv = 1; s.la = 32'h2000; step(s);
    s = nop(); s.acc = 1; step(s);
    do_reset();
    s = nop(); s.rv = 1; s.rt = 3'd0; s.rd = 64'h77; step(s);
    chk("r027_no_rsp", 64'(ld_rsp_valid), 64'd0);
    chk("r027_tag", 64'(dc_req_tag), 64'd0);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) step(rand_stim());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
